// File: rtl/det_count_display.sv
// Counts synchronised detector edges on a 4-digit BCD counter and scans the
// count onto a multiplexed common-anode seven-segment display.
`timescale 1ns/1ps
module det_count_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        det_in,
    input  logic        clr,
    output logic        det_pulse,
    output logic [15:0] count_bcd,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int             CW           = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  REFRESH_LAST = CW'(REFRESH_DIV - 1);

    logic          r_d1, r_d2, r_d3;
    logic          r_c1, r_c2;
    logic [15:0]   r_count;
    logic [CW-1:0] r_refresh;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic [15:0]   w_count_inc;
    logic          w_carry;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;

    function automatic logic [6:0] decode_digit(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // NOTE: non-blocking assignments let each flop sample the previous stage's old value, so the chains shift one stage per edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d1 <= 1'b0;
            r_d2 <= 1'b0;
            r_d3 <= 1'b0;
            r_c1 <= 1'b0;
            r_c2 <= 1'b0;
        end else begin
            r_d1 <= det_in;
            r_d2 <= r_d1;
            r_d3 <= r_d2;
            r_c1 <= clr;
            r_c2 <= r_c1;
        end
    end

    assign det_pulse = r_d2 & ~r_d3;

    // NOTE: every combinational output is given a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_count_inc = r_count;
        w_carry     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (w_carry) begin
                if (r_count[4*k +: 4] == 4'd9) begin
                    w_count_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    // Clear wins over a coincident pulse; carry out of the thousands digit is dropped (9999 -> 0000).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 16'd0;
        end else if (r_c2) begin
            r_count <= 16'd0;
        end else if (det_pulse) begin
            r_count <= w_count_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refresh <= '0;
            r_idx     <= 2'd0;
        end else if (r_refresh == REFRESH_LAST) begin
            r_refresh <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_refresh <= r_refresh + CW'(1);
        end
    end

    // A digit is blanked when it and every higher digit are zero.
    always_comb begin
        w_digit = r_count[3:0];
        w_blank = 1'b0;
        case (r_idx)
            2'd1: begin
                w_digit = r_count[7:4];
                w_blank = (r_count[15:4] == 12'd0);
            end
            2'd2: begin
                w_digit = r_count[11:8];
                w_blank = (r_count[15:8] == 8'd0);
            end
            2'd3: begin
                w_digit = r_count[15:12];
                w_blank = (r_count[15:12] == 4'd0);
            end
            default: begin
                w_digit = r_count[3:0];
                w_blank = 1'b0;
            end
        endcase
        if (w_blank) begin
            w_an  = 4'b1111;
            w_seg = 7'b1111111;
        end else begin
            w_an  = ~(4'b0001 << r_idx);
            w_seg = decode_digit(w_digit);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
        end
    end

    assign count_bcd = r_count;
    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_det_count_display.sv
// Randomised bench for det_count_display: a scoreboard checks the count after
// every det_pulse, and a decimal reference model checks the display scan.
`timescale 1ns/1ps
module tb_det_count_display;

    localparam int DIV = 4;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        det_in = 1'b0;
    logic        clr    = 1'b0;
    logic        det_pulse;
    logic [15:0] count_bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    det_count_display #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .det_in    (det_in),
        .clr       (clr),
        .det_pulse (det_pulse),
        .count_bcd (count_bcd),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_cnt = 0;
    int          cyc;
    logic [15:0] exp_q[$];
    logic        pend = 1'b0;
    logic [15:0] pend_val;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int         pow10   [4]  = '{1, 10, 100, 1000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Leading zero: a digit position above units is blank when the value is below 10^position.
    function automatic void exp_disp(input int c, input int slot,
                                     output logic [3:0] a, output logic [6:0] s);
        if (slot > 0 && c < pow10[slot]) begin
            a = 4'b1111;
            s = 7'b1111111;
        end else begin
            a       = 4'b1111;
            a[slot] = 1'b0;
            s       = seg_tab[(c / pow10[slot]) % 10];
        end
    endfunction

    // Edges since the last reset release; edge n displays slot ((n-1)/DIV) mod 4.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: every det_pulse must be expected, and the next cycle must show the predicted count.
    always @(negedge clk) begin
        if (pend) begin
            check("count_after_pulse", 32'(count_bcd), 32'(pend_val));
            pend = 1'b0;
        end
        if (reset && det_pulse) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got det_pulse=1 at count %h, expected no pulse", count_bcd);
            end else begin
                pend_val = exp_q.pop_front();
                pend     = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        model_cnt = (model_cnt + 1) % 10000;
        exp_q.push_back(to_bcd(model_cnt));
        det_in = 1'b1;
        tick(hi);
        det_in = 1'b0;
        tick(lo);
    endtask

    task automatic rand_pulses(input int n);
        for (int i = 0; i < n; i++) pulse(int'($urandom_range(3, 5)), int'($urandom_range(3, 5)));
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick(int'($urandom_range(3, 6)));
        clr = 1'b0;
        tick(3);
        model_cnt = 0;
        check("clear", 32'(count_bcd), 32'h0);
    endtask

    task automatic check_frame(input string tag);
        logic [3:0] a;
        logic [6:0] s;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            exp_disp(model_cnt, ((cyc - 1) / DIV) % 4, a, s);
            check({tag, "_an"}, 32'(an), 32'(a));
            check({tag, "_seg"}, 32'(seg), 32'(s));
            check({tag, "_dp"}, 32'(dp), 32'h1);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"}, 32'(count_bcd), 32'h0);
        check({tag, "_pulse"}, 32'(det_pulse), 32'h0);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish by 3 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int found;

        // Reset and first frame.
        tick(3);
        #1;
        check_reset_values("t1_rst");
        reset = 1'b1;
        check_frame("t1");

        // Held detection: one pulse two edges after the first sample, count one edge later.
        model_cnt = 1;
        exp_q.push_back(to_bcd(1));
        det_in = 1'b1;
        tick(1);
        check("t2_pulse_e0", 32'(det_pulse), 32'h0);
        tick(1);
        check("t2_pulse_e1", 32'(det_pulse), 32'h1);
        tick(1);
        check("t2_count_e2", 32'(count_bcd), 32'h0001);
        check("t2_pulse_e2", 32'(det_pulse), 32'h0);
        tick(17);
        det_in = 1'b0;
        tick(5);
        check("t2_held_once", 32'(count_bcd), 32'h0001);

        // BCD carry and leading-zero blanking.
        do_clear();
        rand_pulses(10);
        check("t3_count10", 32'(count_bcd), 32'h0010);
        check_frame("t3a");
        rand_pulses(99);
        check("t3_count109", 32'(count_bcd), 32'h0109);
        check_frame("t3b");

        // Preload 9999 then wrap.
        do_clear();
        for (int i = 0; i < 9999; i++) pulse(3, 3);
        check("t4_count9999", 32'(count_bcd), 32'h9999);
        check_frame("t4a");
        pulse(3, 3);
        check("t4_wrap", 32'(count_bcd), 32'h0000);
        check_frame("t4b");

        // Clear coinciding with a detection: the detection is lost.
        rand_pulses(3);
        check("t5_pre", 32'(count_bcd), 32'h0003);
        det_in    = 1'b1;
        clr       = 1'b1;
        model_cnt = 0;
        exp_q.push_back(to_bcd(0));
        tick(4);
        det_in = 1'b0;
        tick(4);
        clr = 1'b0;
        tick(4);
        check("t5_cleared", 32'(count_bcd), 32'h0000);
        rand_pulses(1);
        check("t5_after", 32'(count_bcd), 32'h0001);

        // Mid-scan reset at count 57 during slot 2.
        rand_pulses(56);
        check("t6_count57", 32'(count_bcd), 32'h0057);
        check_frame("t6a");
        found = 0;
        for (int i = 0; i < 8 * DIV && found == 0; i++) begin
            @(negedge clk);
            if (((cyc - 1) / DIV) % 4 == 2) found = 1;
        end
        check("t6_slot2_reached", 32'(found), 32'h1);
        #1 reset = 1'b0;
        #0.5;
        check_reset_values("t6_rst");
        #0.5 reset = 1'b1;
        model_cnt = 0;
        check_frame("t6b");

        // Random tail exercising the scan with a fresh count.
        rand_pulses(int'($urandom_range(5, 25)));
        check("t7_count", 32'(count_bcd), 32'(to_bcd(model_cnt)));
        check_frame("t7");

        tick(4);
        check("scoreboard_drained", 32'(exp_q.size()) + 32'(pend), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/det_count_display.md
# det_count_display

Downstream stage for the sequence-detector output on the board. Counts detection events on a 4-digit BCD counter and drives a multiplexed, common-anode 4-digit seven-segment display. Runs on the fast board clock `clk`. The detector output `det_in` comes from the slowed-clock domain and is treated as asynchronous.

## Interface

Parameters:

- `REFRESH_DIV`, default 100000: `clk` cycles per digit slot. 100000 gives 1 ms per digit at 100 MHz. Legal range is 2 or more.

Ports:

- `clk` input 1: board clock.
- `reset` input 1: asynchronous, active-low reset.
- `det_in` input 1: detector output, asynchronous level.
- `clr` input 1: counter clear request, asynchronous level, active-high.
- `det_pulse` output 1: one-cycle strobe for each counted detection.
- `count_bcd` output 16: the count as four BCD digits, `[15:12]` thousands through `[3:0]` units.
- `an` output 4: digit enables, active-low. `an[0]` is the rightmost (units) digit.
- `seg` output 7: segment drives `{g,f,e,d,c,b,a}`, active-low.
- `dp` output 1: decimal point, active-low, held at 1.

## Operation

**Input synchronisation**
- `det_in` passes through a 3-flop chain `d1 → d2 → d3`.
- `det_pulse = d2 & ~d3`, so it is high for exactly one cycle per rising edge of synchronised `det_in`.
- `clr` passes through its own 2-flop chain `c1 → c2`. `c2` is the effective clear and is level-sensitive.

**Counter**
- When `c2 = 1`, `count_bcd` goes to 0. Clear has priority over a simultaneous `det_pulse`; that detection is lost.
- Otherwise, when `det_pulse = 1`, the count increments by 1 in BCD.
- Carry rule: a digit at 9 goes to 0 and carries into the next digit.
- 9999 wraps to 0000 with no flag.
- A held-high `det_in` counts exactly once. A new count requires `det_in` to fall and rise again.

**Display scan**
- A refresh counter runs 0 to `REFRESH_DIV-1` and wraps.
- On wrap, the digit index advances 0 → 1 → 2 → 3 → 0.
- The digit index selects the slot driven during the next slot period.
- Leading-zero blanking:
  - Digit k (k = 3, 2, 1) is blank when it is 0 and all higher digits are 0.
  - Digit 0 is never blank.
  - A blank slot drives `an = 4'b1111` and `seg = 7'b1111111`.
- A non-blank slot drives `an` with only bit[index] low, and `seg` with the decoded digit.
- Decode values (active-low):

| Digit | `seg` | Digit | `seg` |
|---|---|---|---|
| 0 | 1000000 | 5 | 0010010 |
| 1 | 1111001 | 6 | 0000010 |
| 2 | 0100100 | 7 | 1111000 |
| 3 | 0110000 | 8 | 0000000 |
| 4 | 0011001 | 9 | 0010000 |

- BCD values 10–15 cannot occur. If they did, they would decode to `1111111`.
- `an` and `seg` are registered, recomputed every cycle from the current index and the current `count_bcd`. A count change therefore appears on the display within one cycle.

**Reset**
- `reset = 0` clears the following immediately:
  - all synchroniser flops;
  - `count_bcd` = 0 and `det_pulse` = 0;
  - refresh counter = 0 and digit index = 0;
  - `an = 4'b1111`, `seg = 7'b1111111`, `dp = 1`.
- Reset asserted mid-scan or mid-count aborts everything. Partial counts are not retained.

## Timing

**Detection path**
- `det_in` is sampled high at clk edge E0.
- `det_pulse` is high during the cycle after edge E1.
- `count_bcd` shows the new value after edge E2.
- Latency is 2 edges to the pulse and 3 edges to the count.
- `det_in` high or low for 3 or more cycles is guaranteed to be resolved. Shorter glitches may be dropped.

**Clear path**
- `clr` sampled high at E0 gives `count_bcd = 0` after E2.

**Display path**
- After reset release, the first edge loads `an = 4'b1110` and `seg = 1000000` (digit "0").
- Each slot lasts exactly `REFRESH_DIV` cycles. A full frame lasts `4*REFRESH_DIV` cycles.
- `dp` is constant 1.

## Test plan

Run all scenarios with `REFRESH_DIV = 4`.

1. **Reset:** hold `reset` low, then release. Required: `count_bcd = 0000`; first edge gives `an = 1110`, `seg = 1000000`; `an = 1111` for slots 1–3 (blanked); each slot lasts 4 cycles.
2. **Single and held detection:** drive `det_in` high for 20 cycles. Required: one `det_pulse`, 2 edges after the first sample; `count_bcd = 0001` after the third edge; no further increment while `det_in` stays high.
3. **BCD carry and blanking:** apply 10 pulses. Required: `count_bcd = 0x0010`; slot 1 shows `seg = 1111001` with `an = 1101`; slot 0 shows `1000000`; slots 2–3 blank. Apply 99 more pulses. Required: `0x0109`, with slot 2 now lit.
4. **Wrap:** preload 9999 with 9999 pulses, then apply one more pulse. Required: `count_bcd = 0000`; only digit 0 lit.
5. **Clear priority:** assert `clr` on the same cycle `det_in` rises, so both arrive at `c2`/`det_pulse` together. Required: count 0 and the detection not counted. Deassert `clr`, then apply a new detection. Required: count 1.
6. **Mid-operation reset:** at count 0x0057, during slot 2, pulse `reset` low for 1 ns between edges. Required: all outputs go to reset values immediately; scan restarts at slot 0 after release.
